// File: rtl/n_clic_arbiter_pkg.sv
// Shared sizes, types and the priority-select helper for the N-CLIC arbiter.
package n_clic_arbiter_pkg;

  localparam int unsigned VecSize    = 8;
  localparam int unsigned PrioWidth  = 3;
  localparam int unsigned StackDepth = 4;
  localparam int unsigned IdWidth    = $clog2(VecSize);
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1);

  typedef logic [IdWidth-1:0]    vec_id_t;
  typedef logic [PrioWidth-1:0]  prio_t;
  typedef logic [DepthWidth-1:0] depth_t;

  typedef struct packed {
    logic  en;
    prio_t prio;
  } vec_cfg_t;

  typedef struct packed {
    logic    valid;
    vec_id_t id;
    prio_t   prio;
  } sel_t;

  // Highest priority among eligible vectors; strict '>' keeps the lowest id on ties.
  function automatic sel_t max_prio_sel(input logic [VecSize-1:0] elig,
                                        input prio_t [VecSize-1:0] prios);
    sel_t s;
    s = '0;
    for (int unsigned i = 0; i < VecSize; i++) begin
      if (elig[i] && (!s.valid || prios[i] > s.prio)) begin
        s.valid = 1'b1;
        s.id    = vec_id_t'(i);
        s.prio  = prios[i];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/n_clic_arbiter_if.sv
// Core/config-side bundle of the N-CLIC arbiter; slave is the arbiter, master the core.
interface n_clic_arbiter_if;
  import n_clic_arbiter_pkg::*;

  logic [VecSize-1:0] irq_src;
  logic               cfg_we;
  vec_id_t            cfg_idx;
  logic               cfg_en;
  prio_t              cfg_prio;
  logic               cfg_pend_set;
  logic               take;
  logic               mret;
  logic               int_req;
  vec_id_t            int_id;
  prio_t              int_prio;
  prio_t              threshold;
  depth_t             depth;
  logic               err;

  modport master (
    output irq_src, cfg_we, cfg_idx, cfg_en, cfg_prio, cfg_pend_set, take, mret,
    input  int_req, int_id, int_prio, threshold, depth, err
  );

  modport slave (
    input  irq_src, cfg_we, cfg_idx, cfg_en, cfg_prio, cfg_pend_set, take, mret,
    output int_req, int_id, int_prio, threshold, depth, err
  );

endinterface

// File: rtl/n_clic_prio_stack.sv
// LIFO of saved priority thresholds; push together with pop replaces the top entry.
module n_clic_prio_stack
  import n_clic_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  logic   pop_i,
  input  prio_t  data_i,
  output prio_t  top_c_o,
  output depth_t depth_o
);

  localparam int unsigned IdxW = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  prio_t            mem_q [StackDepth];
  depth_t           depth_q;
  logic [IdxW-1:0]  top_idx_c;
  logic [IdxW-1:0]  push_idx_c;
  logic             empty_c;
  logic             full_c;

  always_comb begin
    empty_c    = (depth_q == '0);
    full_c     = (depth_q == depth_t'(StackDepth));
    top_idx_c  = IdxW'(depth_q - depth_t'(1));
    push_idx_c = IdxW'(depth_q);
    top_c_o    = empty_c ? '0 : mem_q[top_idx_c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      for (int unsigned i = 0; i < StackDepth; i++) mem_q[i] <= '0;
    end else if (push_i && pop_i && !empty_c) begin
      mem_q[top_idx_c] <= data_i;
    end else if (push_i && !full_c) begin
      mem_q[push_idx_c] <= data_i;
      depth_q           <= depth_q + depth_t'(1);
    end else if (pop_i && !empty_c) begin
      depth_q <= depth_q - depth_t'(1);
    end
  end

  assign depth_o = depth_q;

endmodule

// File: rtl/n_clic_arbiter.sv
// N-CLIC nested-interrupt arbiter: edge latching, max-priority select, threshold nesting.
// N_CLIC_OVERRUN_EN adds per-vector saturating overrun counters and the overrun_cnt port.
module n_clic_arbiter
  import n_clic_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  n_clic_arbiter_if.slave bus
`ifdef N_CLIC_OVERRUN_EN
  ,
  output logic [7:0]      overrun_cnt
`endif
);

  logic [VecSize-1:0]    irq_src_q;
  logic [VecSize-1:0]    pending_q, pending_d;
  vec_cfg_t              cfg_q [VecSize];
  prio_t                 threshold_q, threshold_d;
  logic                  int_req_q, req_d;
  vec_id_t               int_id_q;
  prio_t                 int_prio_q;
  logic                  err_q, err_d;

  logic [VecSize-1:0]    event_c, set_c, clr_c, elig_c;
  prio_t [VecSize-1:0]   prios_c;
  sel_t                  sel_c;
  logic                  take_ok_c, mret_ok_c;
  prio_t                 push_data_c;
  prio_t                 stk_top_c;
  depth_t                stk_depth;

  assign event_c   = bus.irq_src & ~irq_src_q;
  assign take_ok_c = bus.take & int_req_q;
  assign mret_ok_c = bus.mret & (stk_depth != '0);

  // Pending update and eligibility; arbitration sees registered state only.
  always_comb begin
    set_c   = '0;
    clr_c   = '0;
    elig_c  = '0;
    prios_c = '0;
    for (int unsigned i = 0; i < VecSize; i++) begin
      set_c[i]   = event_c[i] |
                   (bus.cfg_we & bus.cfg_pend_set & (bus.cfg_idx == vec_id_t'(i)));
      clr_c[i]   = take_ok_c & (int_id_q == vec_id_t'(i));
      elig_c[i]  = pending_q[i] & cfg_q[i].en & (cfg_q[i].prio > threshold_q);
      prios_c[i] = cfg_q[i].prio;
    end
    pending_d = (pending_q & ~clr_c) | set_c;
    sel_c     = max_prio_sel(elig_c, prios_c);
  end

  // Request is dropped in the take cycle and whenever the stack is full.
  always_comb begin
    req_d       = sel_c.valid & (stk_depth != depth_t'(StackDepth)) & ~take_ok_c;
    threshold_d = threshold_q;
    if (take_ok_c) begin
      threshold_d = int_prio_q;
    end else if (mret_ok_c) begin
      threshold_d = stk_top_c;
    end
    push_data_c = mret_ok_c ? stk_top_c : threshold_q;
    err_d       = (bus.mret & (stk_depth == '0)) | (bus.take & ~int_req_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_src_q   <= '0;
      pending_q   <= '0;
      threshold_q <= '0;
      int_req_q   <= 1'b0;
      int_id_q    <= '0;
      int_prio_q  <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < VecSize; i++) cfg_q[i] <= '0;
    end else begin
      irq_src_q   <= bus.irq_src;
      pending_q   <= pending_d;
      threshold_q <= threshold_d;
      int_req_q   <= req_d;
      int_id_q    <= sel_c.id;
      int_prio_q  <= sel_c.prio;
      err_q       <= err_d;
      if (bus.cfg_we) cfg_q[bus.cfg_idx] <= '{en: bus.cfg_en, prio: bus.cfg_prio};
    end
  end

  n_clic_prio_stack u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (take_ok_c),
    .pop_i   (mret_ok_c),
    .data_i  (push_data_c),
    .top_c_o (stk_top_c),
    .depth_o (stk_depth)
  );

  assign bus.int_req   = int_req_q;
  assign bus.int_id    = int_id_q;
  assign bus.int_prio  = int_prio_q;
  assign bus.threshold = threshold_q;
  assign bus.depth     = stk_depth;
  assign bus.err       = err_q;

`ifdef N_CLIC_OVERRUN_EN
  logic [7:0] ovr_q [VecSize];
  logic [7:0] ovr_sel_q;

  // Count events that land on an already-pending vector; config write clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_sel_q <= '0;
      for (int unsigned i = 0; i < VecSize; i++) ovr_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < VecSize; i++) begin
        if (bus.cfg_we && (bus.cfg_idx == vec_id_t'(i))) begin
          ovr_q[i] <= '0;
        end else if (event_c[i] && pending_q[i] && (ovr_q[i] != 8'hFF)) begin
          ovr_q[i] <= ovr_q[i] + 8'd1;
        end
      end
      ovr_sel_q <= ovr_q[bus.cfg_idx];
    end
  end

  assign overrun_cnt = ovr_sel_q;
`endif

endmodule

// File: tb/tb_n_clic_arbiter.sv
// Vector-table bench for n_clic_arbiter with an expected-output scoreboard queue.
module tb_n_clic_arbiter;
  import n_clic_arbiter_pkg::*;

  typedef struct {
    logic [VecSize-1:0] irq;
    logic    we;
    vec_id_t idx;
    logic    en;
    prio_t   prio;
    logic    pend;
    logic    take;
    logic    mret;
    logic    req;
    vec_id_t id;
    prio_t   ip;
    prio_t   thr;
    depth_t  dep;
    logic    err;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  n_clic_arbiter_if bus ();
`ifdef N_CLIC_OVERRUN_EN
  logic [7:0] overrun_cnt;
`endif

  n_clic_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef N_CLIC_OVERRUN_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  vec_t tv[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t V(input logic [VecSize-1:0] irq, input logic we, input int idx,
                             input logic en, input int prio, input logic pend,
                             input logic take, input logic mret, input logic req,
                             input int id, input int ip, input int thr, input int dep,
                             input logic err);
    vec_t v;
    v.irq = irq; v.we = we; v.idx = vec_id_t'(idx); v.en = en; v.prio = prio_t'(prio);
    v.pend = pend; v.take = take; v.mret = mret; v.req = req; v.id = vec_id_t'(id);
    v.ip = prio_t'(ip); v.thr = prio_t'(thr); v.dep = depth_t'(dep); v.err = err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.irq_src      = v.irq;
    bus.cfg_we       = v.we;
    bus.cfg_idx      = v.idx;
    bus.cfg_en       = v.en;
    bus.cfg_prio     = v.prio;
    bus.cfg_pend_set = v.pend;
    bus.take         = v.take;
    bus.mret         = v.mret;
  endtask

  task automatic check(input string tag);
    vec_t e;
    logic ok;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e  = exp_q.pop_front();
      ok = (bus.int_req === e.req) && (bus.threshold === e.thr) && (bus.depth === e.dep) &&
           (bus.err === e.err) &&
           (!e.req || ((bus.int_id === e.id) && (bus.int_prio === e.ip)));
      if (!ok) begin
        fails++;
        $display("FAIL %s: got req=%0d id=%0d prio=%0d thr=%0d depth=%0d err=%0d, want req=%0d id=%0d prio=%0d thr=%0d depth=%0d err=%0d",
                 tag, bus.int_req, bus.int_id, bus.int_prio, bus.threshold, bus.depth, bus.err,
                 e.req, e.id, e.ip, e.thr, e.dep, e.err);
      end
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check(tag);
  endtask

`ifdef N_CLIC_OVERRUN_EN
  task automatic check_cnt(input string tag, input logic [7:0] want);
    tests++;
    if (overrun_cnt !== want) begin
      fails++;
      $display("FAIL %s: overrun_cnt got %0d want %0d", tag, overrun_cnt, want);
    end
  endtask
`endif

  initial begin
    //              irq   we idx en pr pd tk mr   req id ip thr dep err
    tv.push_back(V(8'h00, 1, 3, 1, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h08, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 3, 2, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 2, 1, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 1, 0));
    tv.push_back(V(8'h00, 1, 5, 1, 4, 0, 0, 0,   0, 0, 0, 2, 1, 0));
    tv.push_back(V(8'h20, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 1, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 5, 4, 2, 1, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 4, 2, 0));
    tv.push_back(V(8'h00, 1, 1, 1, 3, 0, 0, 0,   0, 0, 0, 4, 2, 0));
    tv.push_back(V(8'h02, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 4, 2, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 4, 2, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 2, 1, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 1, 3, 2, 1, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 3, 2, 0));
    tv.push_back(V(8'h00, 1, 2, 1, 5, 0, 0, 0,   0, 0, 0, 3, 2, 0));
    tv.push_back(V(8'h00, 1, 6, 1, 5, 0, 0, 0,   0, 0, 0, 3, 2, 0));
    tv.push_back(V(8'h44, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 2, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 2, 5, 3, 2, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 5, 3, 0));
    tv.push_back(V(8'h00, 1, 7, 1, 6, 0, 0, 0,   0, 0, 0, 5, 3, 0));
    tv.push_back(V(8'h00, 1, 0, 1, 7, 0, 0, 0,   0, 0, 0, 5, 3, 0));
    tv.push_back(V(8'h80, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 5, 3, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 7, 6, 5, 3, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 6, 4, 0));
    tv.push_back(V(8'h01, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 6, 4, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 6, 4, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 6, 4, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 5, 3, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 0, 7, 5, 3, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 7, 3, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 3, 2, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 6, 5, 3, 2, 0));
    tv.push_back(V(8'h40, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 5, 3, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 3, 2, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 6, 5, 3, 2, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 5, 3, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 3, 2, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 2, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 2, 1, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h00, 1, 4, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 4, 1, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 1, 0));
    tv.push_back(V(8'h00, 1, 3, 1, 2, 1, 0, 0,   0, 0, 0, 1, 1, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 3, 2, 1, 1, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 2, 1, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h00, 1, 5, 1, 4, 1, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 5, 4, 0, 0, 0));
    tv.push_back(V(8'h00, 1, 5, 0, 4, 0, 0, 0,   1, 5, 4, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h00, 1, 5, 1, 4, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 0, 0,   1, 5, 4, 0, 0, 0));
    tv.push_back(V(8'h00, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 4, 1, 0));

    drive(V(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    step(V(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset_c1");
    step(V(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset_c2");
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) step(tv[i], $sformatf("vec%0d", i));

    // Reset while a handler is active, with mret asserted: no err, stack emptied.
    reset = 1'b1;
    step(V(8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "reset_mid");
    reset = 1'b0;
    step(V(8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), "post_reset_mret");
    step(V(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset_idle");

`ifdef N_CLIC_OVERRUN_EN
    step(V(8'h00, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "ovr_setup");
    for (int i = 0; i < 3; i++) begin
      step(V(8'h10, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovr_hi");
      step(V(8'h00, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovr_lo");
    end
    step(V(8'h00, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovr_idle");
    check_cnt("ovr_three", 8'd3);
    for (int i = 0; i < 300; i++) begin
      step(V(8'h10, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovr_hi");
      step(V(8'h00, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovr_lo");
    end
    step(V(8'h00, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovr_idle");
    check_cnt("ovr_saturate", 8'd255);
    step(V(8'h00, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovr_clear");
    step(V(8'h00, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovr_idle");
    check_cnt("ovr_cleared", 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
